gerenciador_atributos: RTL
==========================

Name: gerenciador_atributos

Overview:
Owns the three pet attributes (fome, sono, felicidade) that feed controlador_estados, and sequences their periodic update from the current estado. A prescaler generates an update tick. On each tick a small FSM updates the three attributes one per cycle, sharing a single saturating add/sub unit. It sits between controlador_estados (estado in) and the display/state logic (attributes out).

Parameters:
TICK_DIV, 50000, clock cycles per update tick; must be >= 8
DECAY, 1, amount subtracted per tick from an attribute that is not being restored
GAIN, 4, amount added per tick to the attribute restored by the current activity
MAX_VAL, 255, saturation ceiling for all attributes; must be <= 255
INIT_VAL, 128, value loaded into every attribute on rst or reiniciar

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
estado  input  4  one-hot activity code: IDLE 4'b0000, DORMINDO 4'b0001, COMENDO 4'b0010, DANDO_AULA 4'b0100, MORTO 4'b1000
reiniciar  input  1  synchronous restart; reloads attributes and restarts the prescaler
fome  output  8  hunger level, 0 = starved
sono  output  8  rest level, 0 = exhausted
felicidade  output  8  happiness level, 0 = miserable
ocupado  output  1  high while an update sequence is in progress
tick  output  1  one-cycle pulse when an update sequence starts

Behaviour:
- Reset (rst high, asynchronous): fome = sono = felicidade = INIT_VAL; ocupado = 0; tick = 0; prescaler = 0; FSM = ESPERA; latched estado = IDLE.
- Prescaler: counts 0..TICK_DIV-1 and wraps. In the cycle where the count equals TICK_DIV-1, tick is registered high for the following cycle.
- FSM states and transitions:
  - ESPERA: on a prescaler wrap, go to UPD_FOME and latch estado into est_q.
  - UPD_FOME: write fome, then go to UPD_SONO.
  - UPD_SONO: write sono, then go to UPD_FELIC.
  - UPD_FELIC: write felicidade, then go to ESPERA.
- Latency: fome changes 1 edge after entering UPD_FOME, sono 1 edge later, felicidade 1 edge after that.
  - ocupado is high exactly during UPD_FOME, UPD_SONO and UPD_FELIC (3 cycles); it rises in the same cycle as tick.
- All three updates use est_q, so an estado change mid-sequence takes effect only on the next tick.
- Update rules. Exactly one add/sub operation runs per cycle through the shared unit.
  - fome: +GAIN if est_q = COMENDO, otherwise -DECAY.
  - sono: +GAIN if est_q = DORMINDO; -2*DECAY if est_q = DANDO_AULA; otherwise -DECAY.
  - felicidade: +GAIN if est_q = DANDO_AULA, otherwise -DECAY.
  - est_q = MORTO, or any non-one-hot code: no attribute changes. The FSM still walks the states, and ocupado and tick still pulse.
- Arithmetic: computed 9 bits wide. A subtraction whose result goes below 0 clamps to 0. An addition whose result exceeds MAX_VAL clamps to MAX_VAL. No wrap-around ever occurs.
- Once an attribute is at 0, it stays at 0 under decay. Reaching 0 is what drives controlador_estados to MORTO.
- reiniciar (synchronous, highest priority after rst):
  - On the next edge, all attributes = INIT_VAL, prescaler = 0, FSM = ESPERA, ocupado = 0, tick = 0.
  - If asserted mid-sequence, the sequence is aborted with no partial write.
- reiniciar held high: all outputs stay at their restart values and the prescaler stays at 0.
- A wrap that coincides with reiniciar is discarded.
- Wrap while busy: impossible because TICK_DIV >= 8. An implementation may assert a simulation-only check for it.

Test Plan:
- TICK_DIV=8, estado=IDLE, release rst -> tick at cycle 8; fome 128->127, then sono 128->127, then felicidade 128->127 on successive edges; ocupado high for 3 cycles.
- estado=COMENDO over 2 ticks -> fome 128->132->136; sono and felicidade 128->127->126.
- estado=DANDO_AULA, sono preloaded to 1 via DECAY=1 runs -> sono clamps to 0, not 255; felicidade +4 per tick.
- estado=DORMINDO, sono at 253 -> next tick sono = 255 (saturates); tick after that sono stays 255.
- estado switches to MORTO one cycle into UPD_FOME -> current sequence still uses its latched code; next tick leaves all three unchanged while ocupado still pulses.
- reiniciar asserted during UPD_SONO with fome already 120 -> next edge all three = 128, ocupado = 0, next tick exactly TICK_DIV cycles after reiniciar deasserts; rst asserted mid-cycle -> outputs reset immediately, without waiting for clk.

Source files
------------

// File: rtl/gerenciador_atributos.sv
// rtl/gerenciador_atributos.sv - pet attribute store with prescaled, sequenced saturating updates
//
// Keeps fome, sono and felicidade and updates them once per prescaler tick.
// A three-step FSM writes one attribute per cycle through a shared
// saturating add/sub unit, using the activity code latched at the tick.
//
// Ports:
//   clk        in   1  system clock
//   rst        in   1  asynchronous active-high reset
//   estado     in   4  one-hot activity code from controlador_estados
//   reiniciar  in   1  synchronous restart (attributes, prescaler, FSM)
//   fome       out  8  hunger level, 0 = starved
//   sono       out  8  rest level, 0 = exhausted
//   felicidade out  8  happiness level, 0 = miserable
//   ocupado    out  1  high during the three update cycles
//   tick       out  1  one-cycle pulse when an update sequence starts

module gerenciador_atributos #(
  parameter int TICK_DIV = 50000,
  parameter int DECAY    = 1,
  parameter int GAIN     = 4,
  parameter int MAX_VAL  = 255,
  parameter int INIT_VAL = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] estado,
  input  logic       reiniciar,
  output logic [7:0] fome,
  output logic [7:0] sono,
  output logic [7:0] felicidade,
  output logic       ocupado,
  output logic       tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  localparam logic [7:0] INIT8 = 8'(INIT_VAL);
  localparam logic [7:0] MAX8  = 8'(MAX_VAL);
  localparam logic [8:0] MAX9  = 9'(MAX_VAL);
  localparam logic [8:0] GAIN9 = 9'(GAIN);
  localparam logic [8:0] DEC1  = 9'(DECAY);
  localparam logic [8:0] DEC2  = 9'(2 * DECAY);

  localparam logic [3:0] EST_IDLE       = 4'b0000;
  localparam logic [3:0] EST_DORMINDO   = 4'b0001;
  localparam logic [3:0] EST_COMENDO    = 4'b0010;
  localparam logic [3:0] EST_DANDO_AULA = 4'b0100;

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    UPD_FOME  = 2'd1,
    UPD_SONO  = 2'd2,
    UPD_FELIC = 2'd3
  } fsm_t;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } op_t;

  fsm_t       state;
  fsm_t       state_next;
  logic [CW-1:0] cnt;
  logic       wrap;
  logic [3:0] est_q;
  logic       est_valid;

  op_t        op_kind;
  logic [7:0] op_a;
  logic [8:0] op_amt;
  logic [8:0] sum9;
  logic [7:0] diff8;
  logic [7:0] result;

  assign wrap = (cnt == CNT_LAST);

  // Prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (reiniciar || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A wrap coinciding with reiniciar is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= wrap && !reiniciar;
    end
  end

  // FSM state register and activity latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ESPERA;
      est_q <= EST_IDLE;
    end else if (reiniciar) begin
      state <= ESPERA;
      est_q <= EST_IDLE;
    end else begin
      state <= state_next;
      if (state == ESPERA && wrap) begin
        est_q <= estado;
      end
    end
  end

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      ESPERA:    if (wrap) state_next = UPD_FOME;
      UPD_FOME:  state_next = UPD_SONO;
      UPD_SONO:  state_next = UPD_FELIC;
      UPD_FELIC: state_next = ESPERA;
      default:   state_next = ESPERA;
    endcase
  end

  // FSM outputs: busy flag and operand selection for the shared unit.
  // MORTO and any code outside the known set leave attributes untouched.
  always_comb begin
    ocupado   = (state != ESPERA);
    op_kind   = OP_HOLD;
    op_a      = fome;
    op_amt    = '0;
    est_valid = 1'b0;
    case (est_q)
      EST_IDLE, EST_DORMINDO, EST_COMENDO, EST_DANDO_AULA: est_valid = 1'b1;
      default: est_valid = 1'b0;
    endcase
    case (state)
      UPD_FOME: begin
        op_a = fome;
        if (est_valid) begin
          if (est_q == EST_COMENDO) begin
            op_kind = OP_ADD;
            op_amt  = GAIN9;
          end else begin
            op_kind = OP_SUB;
            op_amt  = DEC1;
          end
        end
      end
      UPD_SONO: begin
        op_a = sono;
        if (est_valid) begin
          if (est_q == EST_DORMINDO) begin
            op_kind = OP_ADD;
            op_amt  = GAIN9;
          end else if (est_q == EST_DANDO_AULA) begin
            op_kind = OP_SUB;
            op_amt  = DEC2;
          end else begin
            op_kind = OP_SUB;
            op_amt  = DEC1;
          end
        end
      end
      UPD_FELIC: begin
        op_a = felicidade;
        if (est_valid) begin
          if (est_q == EST_DANDO_AULA) begin
            op_kind = OP_ADD;
            op_amt  = GAIN9;
          end else begin
            op_kind = OP_SUB;
            op_amt  = DEC1;
          end
        end
      end
      default: begin
        op_kind = OP_HOLD;
      end
    endcase
  end

  // Shared saturating add/sub. The subtract only uses the low byte of the
  // amount once the 9-bit compare has ruled out underflow.
  always_comb begin
    sum9  = {1'b0, op_a} + op_amt;
    diff8 = op_a - op_amt[7:0];
    case (op_kind)
      OP_ADD:  result = (sum9 > MAX9) ? MAX8 : sum9[7:0];
      OP_SUB:  result = (op_amt > {1'b0, op_a}) ? 8'd0 : diff8;
      default: result = op_a;
    endcase
  end

  // Attribute registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fome       <= INIT8;
      sono       <= INIT8;
      felicidade <= INIT8;
    end else if (reiniciar) begin
      fome       <= INIT8;
      sono       <= INIT8;
      felicidade <= INIT8;
    end else begin
      case (state)
        UPD_FOME:  fome       <= result;
        UPD_SONO:  sono       <= result;
        UPD_FELIC: felicidade <= result;
        default:   ;
      endcase
    end
  end

endmodule
